// File: rtl/axil_sum_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_sum_master
// Description : AXI4-Lite initiator that drives the adder slave without a
//               processor. On start it writes operand A (BASE+0x0) and
//               operand B (BASE+0x4), then reads the sum (BASE+0x8). It
//               presents rdata[7:0] on sum with a one-cycle done strobe.
// Ports       : clock_rtl / reset_rtl_0 - clock, async active-low reset
//               start, op_a, op_b        - sequence request and operands
//               sum, done, busy, error   - result, strobe, status, sticky err
//               m_axi_*                  - AXI4-Lite master channels
// Revision    : 1.0 - initial release
// ============================================================================
module axil_sum_master #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h44A0_0000)
) (
  input  logic                  clock_rtl,
  input  logic                  reset_rtl_0,
  input  logic                  start,
  input  logic [7:0]            op_a,
  input  logic [7:0]            op_b,
  output logic [7:0]            sum,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_A   = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] ADDR_B   = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SUM = BASE_ADDR + ADDR_WIDTH'(8);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_A = 3'd1,
    BR_A = 3'd2,
    WR_B = 3'd3,
    BR_B = 3'd4,
    AR   = 3'd5,
    RD   = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              op_b_q, op_b_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [7:0]              sum_q, sum_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;

  // A channel is still pending if its valid is up and not being accepted now.
  logic aw_pend, w_pend;
  assign aw_pend = awvalid_q & ~m_axi_awready;
  assign w_pend  = wvalid_q  & ~m_axi_wready;

  // Only the low byte of the read data carries the sum.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^m_axi_rdata[31:8];

  always_comb begin
    state_d   = state_q;
    op_b_d    = op_b_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    awvalid_d = aw_pend;
    wvalid_d  = w_pend;
    sum_d     = sum_q;
    error_d   = error_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_b_d    = op_b;
          error_d   = 1'b0;
          awaddr_d  = ADDR_A;
          wdata_d   = {24'h0, op_a};
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_A;
        end
      end
      WR_A: if (!aw_pend && !w_pend) state_d = BR_A;
      BR_A: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) error_d = 1'b1;
          awaddr_d  = ADDR_B;
          wdata_d   = {24'h0, op_b_q};
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_B;
        end
      end
      WR_B: if (!aw_pend && !w_pend) state_d = BR_B;
      BR_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) error_d = 1'b1;
          araddr_d = ADDR_SUM;
          state_d  = AR;
        end
      end
      AR: if (m_axi_arready) state_d = RD;
      RD: begin
        if (m_axi_rvalid) begin
          sum_d = m_axi_rdata[7:0];
          if (m_axi_rresp != 2'b00) error_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Readies, arvalid and busy are pure functions of the next state, so
    // registering them keeps every output flop-driven.
    bready_d  = (state_d == BR_A) || (state_d == BR_B);
    arvalid_d = (state_d == AR);
    rready_d  = (state_d == RD);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clock_rtl or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      state_q   <= IDLE;
      op_b_q    <= 8'h00;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= 32'h0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      sum_q     <= 8'h00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_b_q    <= op_b_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      sum_q     <= sum_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
    end
  end

  assign sum           = sum_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign error         = error_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_sum_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_sum_master
// Description : Self-checking bench for axil_sum_master with a reactive
//               AXI4-Lite slave model (programmable ready stalls and
//               responses) and a table of directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_sum_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  op_a = 8'h00, op_b = 8'h00;
  logic [7:0]  sum;
  logic        done, busy, error;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_tests = 0;
  int n_fail  = 0;

  axil_sum_master dut (
    .clock_rtl(clk), .reset_rtl_0(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .sum(sum), .done(done), .busy(busy), .error(error),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial forever #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic [1:0]  s_bresp_a = 2'b00, s_bresp_b = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'h0;
  logic        got_aw, got_w;
  logic [31:0] cur_addr, cur_data;
  logic [31:0] wq_addr[$], wq_data[$], rq_addr[$];

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid  && (w_cnt  >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
      got_aw = 1'b0; got_w = 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (bvalid && bready) bvalid <= 1'b0;
      if (rvalid && rready) rvalid <= 1'b0;
      if (awvalid && awready) begin got_aw = 1'b1; cur_addr = awaddr; end
      if (wvalid && wready)   begin got_w  = 1'b1; cur_data = wdata;  end
      if (got_aw && got_w) begin
        wq_addr.push_back(cur_addr);
        wq_data.push_back(cur_data);
        bvalid <= 1'b1;
        bresp  <= (cur_addr[3:0] == 4'h4) ? s_bresp_b : s_bresp_a;
        got_aw = 1'b0; got_w = 1'b0;
      end
      if (arvalid && arready) begin
        rq_addr.push_back(araddr);
        rvalid <= 1'b1; rdata <= s_rdata; rresp <= s_rresp;
      end
    end
  end

  // Stability monitor: a valid not accepted must stay up with stable payload.
  int          n_viol = 0;
  logic        aw_hold, w_hold, ar_hold;
  logic [31:0] aw_hold_addr, w_hold_data, ar_hold_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
    end else begin
      if ((aw_hold && (!awvalid || awaddr !== aw_hold_addr)) ||
          (w_hold  && (!wvalid  || wdata  !== w_hold_data))  ||
          (ar_hold && (!arvalid || araddr !== ar_hold_addr)))
        n_viol <= n_viol + 1;
      aw_hold <= awvalid && !awready; aw_hold_addr <= awaddr;
      w_hold  <= wvalid  && !wready;  w_hold_data  <= wdata;
      ar_hold <= arvalid && !arready; ar_hold_addr <= araddr;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a, b;
    logic [31:0] rd;
    logic [1:0]  bra, brb, rr;
    int          awd, wd, ard;
    logic [7:0]  exp_sum;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    wq_addr.delete(); wq_data.delete(); rq_addr.delete();
  endtask

  task automatic run_seq(input string nm, input vec_t v);
    int lat;
    int v0;
    aw_dly = v.awd; w_dly = v.wd; ar_dly = v.ard;
    s_rdata = v.rd; s_bresp_a = v.bra; s_bresp_b = v.brb; s_rresp = v.rr;
    clear_logs();
    v0 = n_viol;
    @(negedge clk); op_a = v.a; op_b = v.b; start = 1'b1;
    @(negedge clk); start = 1'b0; op_a = 8'hEE; op_b = 8'hEE;
    chk({nm, ".busy_rise"}, 32'(busy), 32'd1);
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      if (done) begin lat = c; break; end
      @(negedge clk);
    end
    chk({nm, ".latency"}, lat, v.exp_lat);
    chk({nm, ".sum"}, 32'(sum), 32'(v.exp_sum));
    chk({nm, ".error"}, 32'(error), 32'(v.exp_err));
    chk({nm, ".busy_fall"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({nm, ".done_pulse"}, 32'(done), 32'd0);
    chk({nm, ".n_writes"}, wq_addr.size(), 32'd2);
    chk({nm, ".awaddr_a"}, qget(wq_addr, 0), 32'h44A0_0000);
    chk({nm, ".wdata_a"}, qget(wq_data, 0), {24'h0, v.a});
    chk({nm, ".awaddr_b"}, qget(wq_addr, 1), 32'h44A0_0004);
    chk({nm, ".wdata_b"}, qget(wq_data, 1), {24'h0, v.b});
    chk({nm, ".n_reads"}, rq_addr.size(), 32'd1);
    chk({nm, ".araddr"}, qget(rq_addr, 0), 32'h44A0_0008);
    chk({nm, ".stable"}, n_viol - v0, 32'd0);
  endtask

  initial begin
    int first, last, ndone, bad_int, found;
    //            a      b      rdata          bra    brb    rr   awd wd ard sum    err lat
    vecs[0] = '{8'd3,  8'd4,  32'd7,         2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h07, 1'b0, 7};
    vecs[1] = '{8'hFF, 8'h02, 32'h0000_0101, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'h01, 1'b0, 7};
    vecs[2] = '{8'h10, 8'h20, 32'hABCD_EF30, 2'b00, 2'b10, 2'b00, 0, 0, 0, 8'h30, 1'b1, 7};
    vecs[3] = '{8'h05, 8'h06, 32'h0000_000B, 2'b00, 2'b00, 2'b00, 4, 1, 0, 8'h0B, 1'b0, 15};
    vecs[4] = '{8'h01, 8'h01, 32'h0000_0002, 2'b00, 2'b00, 2'b00, 0, 3, 0, 8'h02, 1'b0, 13};
    vecs[5] = '{8'h07, 8'h08, 32'h0000_000F, 2'b00, 2'b00, 2'b10, 0, 0, 2, 8'h0F, 1'b1, 9};
    vecs[6] = '{8'h00, 8'h00, 32'h0000_0000, 2'b11, 2'b00, 2'b00, 0, 0, 0, 8'h00, 1'b1, 7};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.sum", 32'(sum), 32'h0);
    chk("rst.flags", {28'h0, done, busy, error, 1'b0}, 32'h0);
    chk("rst.valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    chk("rst.awaddr", awaddr, 32'h0);
    chk("rst.wdata", wdata, 32'h0);
    chk("rst.araddr", araddr, 32'h0);
    chk("const.prot_strb", {21'h0, awprot, arprot, wstrb, 1'b0}, {21'h0, 3'b000, 3'b000, 4'hF, 1'b0});

    // Table-driven sequences (error in vec 2 is cleared by vec 3's start)
    for (int i = 0; i < 7; i++) run_seq($sformatf("vec%0d", i), vecs[i]);

    // Reset pulsed while in BR_A
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    @(negedge clk); op_a = 8'h11; op_b = 8'h22; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (bready) begin found = 1; break; end
      @(negedge clk);
    end
    chk("rstmid.reach_br_a", found, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.outputs", {26'h0, awvalid, wvalid, bready, arvalid, rready, busy}, 32'h0);
    chk("rstmid.error_done", {30'h0, done, error}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    clear_logs();
    repeat (4) @(negedge clk);
    chk("rstmid.idle", {30'h0, busy, awvalid}, 32'h0);
    chk("rstmid.no_writes", wq_addr.size(), 32'd0);
    run_seq("after_rst", vecs[0]);

    // Back-to-back with start held high
    s_rdata = 32'd9; s_bresp_a = 2'b00; s_bresp_b = 2'b00; s_rresp = 2'b00;
    clear_logs();
    first = -1; last = -1; ndone = 0; bad_int = 0;
    @(negedge clk); op_a = 8'd4; op_b = 8'd5; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = c;
        else if (c - last != 7) bad_int++;
        last = c;
        ndone++;
      end
    end
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("b2b.first_done", first, 32'd7);
    chk("b2b.interval", bad_int, 32'd0);
    chk("b2b.n_done", ndone, 32'd6);
    chk("b2b.n_writes", wq_addr.size(), 32'd12);
    chk("b2b.n_reads", rq_addr.size(), 32'd6);
    chk("b2b.idle", 32'(busy), 32'd0);

    // Start pulses while busy are ignored
    clear_logs();
    @(negedge clk); op_a = 8'd1; op_b = 8'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    first = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2 || c == 4) start = 1'b1; else start = 1'b0;
      if (done && first < 0) first = c;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore.latency", first, 32'd7);
    chk("ignore.n_writes", wq_addr.size(), 32'd2);
    chk("ignore.n_reads", rq_addr.size(), 32'd1);
    chk("ignore.idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
